// File: rtl/wb_burst_reader.sv
// Wishbone burst-read master: fetches a block of 32-bit words with linear incrementing
// bursts, buffers them in a FIFO and presents them on a valid/ready stream.
module wb_burst_reader #(
  parameter int BURST_LEN  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] base_adr,
  input  logic [15:0] nb_words,
  output logic        busy,
  output logic        done,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [31:0] wb_adr,
  output logic [3:0]  wb_sel,
  output logic [2:0]  wb_cti,
  output logic [1:0]  wb_bte,
  input  logic [31:0] wb_dat_sm,
  input  logic        wb_ack,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  if (BURST_LEN < 1 || FIFO_DEPTH < BURST_LEN || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
    $error("wb_burst_reader: FIFO_DEPTH must be a power of 2 and >= BURST_LEN >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_ROOM,
    S_BURST,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   adr_q, adr_d;
  logic [15:0]   rem_q, rem_d;
  logic [15:0]   beat_q, beat_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;

  logic          in_burst;
  logic          push;
  logic          pop;
  logic [15:0]   beats_w;
  logic [16:0]   free_w;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign in_burst  = (state_q == S_BURST);
  assign push      = in_burst & wb_ack;
  assign out_valid = (cnt_q != '0);
  assign pop       = out_valid & out_ready;

  // A pop in the same cycle frees a slot in time for the next burst's first push.
  assign beats_w = (rem_q > 16'(BURST_LEN)) ? 16'(BURST_LEN) : rem_q;
  assign free_w  = 17'(FIFO_DEPTH) - 17'(cnt_q) + 17'(pop);

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    rem_d   = rem_q;
    beat_d  = beat_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          adr_d   = base_adr & ~32'd3;
          rem_d   = nb_words;
          state_d = (nb_words == 16'd0) ? S_DONE : S_WAIT_ROOM;
        end
      end
      S_WAIT_ROOM: begin
        if ({1'b0, beats_w} <= free_w) begin
          beat_d  = beats_w;
          state_d = S_BURST;
        end
      end
      S_BURST: begin
        if (wb_ack) begin
          adr_d  = adr_q + 32'd4;
          rem_d  = rem_q - 16'd1;
          beat_d = beat_q - 16'd1;
          if (beat_q == 16'd1) begin
            state_d = (rem_q == 16'd1) ? S_DRAIN : S_WAIT_ROOM;
          end
        end
      end
      S_DRAIN: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      adr_q   <= '0;
      rem_q   <= '0;
      beat_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      rem_q   <= rem_d;
      beat_q  <= beat_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_q] <= wb_dat_sm;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        wr_q <= ptr_inc(wr_q);
      end
      if (pop) begin
        rd_q <= ptr_inc(rd_q);
      end
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Head word is masked while empty so the stream reads as zero after reset.
  assign out_data = out_valid ? mem[rd_q] : '0;

  assign busy   = busy_q;
  assign done   = done_q;
  assign wb_cyc = in_burst;
  assign wb_stb = in_burst;
  assign wb_we  = 1'b0;
  assign wb_adr = adr_q;
  assign wb_sel = 4'b1111;
  assign wb_cti = in_burst ? ((beat_q == 16'd1) ? 3'b111 : 3'b010) : 3'b000;
  assign wb_bte = 2'b00;

endmodule

// File: tb/tb_wb_burst_reader.sv
// Bench for wb_burst_reader: random-stall slave and consumer, expected beats and words
// derived from the block address arithmetic and burst partitioning.
module tb_wb_burst_reader;
  localparam int BL = 8;
  localparam int FD = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] base_adr;
  logic [15:0] nb_words;
  logic        busy, done, wb_cyc, wb_stb, wb_we;
  logic [31:0] wb_adr;
  logic [3:0]  wb_sel;
  logic [2:0]  wb_cti;
  logic [1:0]  wb_bte;
  logic [31:0] wb_dat_sm;
  logic        wb_ack;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;

  wb_burst_reader #(.BURST_LEN(BL), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .start(start), .base_adr(base_adr), .nb_words(nb_words),
    .busy(busy), .done(done), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
    .wb_adr(wb_adr), .wb_sel(wb_sel), .wb_cti(wb_cti), .wb_bte(wb_bte),
    .wb_dat_sm(wb_dat_sm), .wb_ack(wb_ack), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_adr_q[$];
  logic [31:0] exp_data_q[$];
  logic [2:0]  exp_cti_q[$];
  int ack_pct = 100;
  int ready_pct = 100;
  bit hold_ready = 1'b0;
  bit mon_en = 1'b0;
  int beats_seen = 0, pops_seen = 0, done_count = 0, bursts_seen = 0;
  logic cyc_prev = 1'b0;
  int b0, d0, k0, p0;

  function automatic logic [31:0] slave_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5EEDC0DE;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Slave, consumer and bus observer; all decisions made on the falling edge.
  always @(negedge clk) begin
    if (rst !== 1'b1 || !mon_en) begin
      wb_ack    = 1'b0;
      wb_dat_sm = '0;
      out_ready = 1'b0;
      cyc_prev  = wb_cyc;
    end else begin
      if (wb_stb) wb_ack = ($urandom_range(0, 99) < ack_pct);
      else        wb_ack = 1'($urandom_range(0, 1));
      wb_dat_sm = (wb_stb && wb_ack) ? slave_word(wb_adr) : $urandom();
      out_ready = !hold_ready && ($urandom_range(0, 99) < ready_pct);
      check("bus_const", {wb_we, wb_sel, wb_bte, wb_cyc ^ wb_stb, wb_stb ? 3'b000 : wb_cti},
            {1'b0, 4'hF, 2'b00, 1'b0, 3'b000});
      if (wb_stb && wb_ack) begin
        if (exp_adr_q.size() == 0) check("beat_extra", 1, 0);
        else begin
          check("beat_adr", wb_adr, exp_adr_q.pop_front());
          check("beat_cti", 32'(wb_cti), 32'(exp_cti_q.pop_front()));
        end
        beats_seen++;
      end
      if (out_valid && out_ready) begin
        if (exp_data_q.size() == 0) check("pop_extra", 1, 0);
        else check("pop_data", out_data, exp_data_q.pop_front());
        pops_seen++;
      end
      if (wb_cyc && !cyc_prev) bursts_seen++;
      cyc_prev = wb_cyc;
      if (done) done_count++;
    end
  end

  task automatic build_model(input logic [31:0] base, input int n);
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      a = (base & ~32'd3) + 32'(4 * i);
      exp_adr_q.push_back(a);
      exp_cti_q.push_back(((i % BL) == BL - 1 || i == n - 1) ? 3'b111 : 3'b010);
      exp_data_q.push_back(slave_word(a));
    end
  endtask

  task automatic clear_model();
    exp_adr_q.delete();
    exp_cti_q.delete();
    exp_data_q.delete();
  endtask

  task automatic start_xfer(input string tag, input logic [31:0] base, input int n);
    build_model(base, n);
    b0 = bursts_seen; d0 = done_count; k0 = beats_seen; p0 = pops_seen;
    @(negedge clk); #1;
    base_adr = base; nb_words = 16'(n); start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    base_adr = $urandom();
    nb_words = 16'($urandom_range(1, 50));
    check({tag, "_busy_after_start"}, 32'(busy), 1);
  endtask

  task automatic finish_xfer(input string tag, input int n);
    int waited = 0;
    while (done_count == d0 && waited < 3000) begin
      @(negedge clk); #1;
      waited++;
    end
    check({tag, "_done_seen"}, 32'(done_count - d0), 1);
    check({tag, "_busy_at_done"}, 32'(busy), 0);
    repeat (4) @(negedge clk);
    #1;
    check({tag, "_single_done"}, 32'(done_count - d0), 1);
    check({tag, "_beats"}, 32'(beats_seen - k0), 32'(n));
    check({tag, "_pops"}, 32'(pops_seen - p0), 32'(n));
    check({tag, "_bursts"}, 32'(bursts_seen - b0), 32'((n + BL - 1) / BL));
    check({tag, "_model_left"}, 32'(exp_adr_q.size() + exp_data_q.size()), 0);
    clear_model();
  endtask

  task automatic run_xfer(input string tag, input logic [31:0] base, input int n);
    start_xfer(tag, base, n);
    finish_xfer(tag, n);
  endtask

  initial begin
    int waited;
    rst = 1'b0; start = 1'b0; base_adr = '0; nb_words = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_flags", {busy, done, wb_cyc, wb_stb, out_valid, wb_we}, '0);
    check("reset_adr", wb_adr, 0);
    check("reset_cti", 32'(wb_cti), 0);
    check("reset_out_data", out_data, 0);
    rst = 1'b1;
    mon_en = 1'b1;

    // One short burst, then 8/8/4
    run_xfer("t1", 32'h0000_0100, 5);
    run_xfer("t2", 32'h0000_1000, 20);

    // Consumer stalled: only the FIFO's worth is fetched
    start_xfer("t3", 32'h0000_2000, 20);
    hold_ready = 1'b1;
    repeat (200) @(negedge clk);
    #1;
    check("t3_acked_while_stalled", 32'(beats_seen - k0), 16);
    check("t3_stb_low_waiting", 32'(wb_stb), 0);
    check("t3_no_pops", 32'(pops_seen - p0), 0);
    check("t3_out_valid", 32'(out_valid), 1);
    hold_ready = 1'b0;
    finish_xfer("t3", 20);

    // Zero-length request
    b0 = bursts_seen; d0 = done_count;
    @(negedge clk); #1;
    nb_words = '0; base_adr = 32'h0000_3000; start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    check("t4_busy_c1", 32'(busy), 1);
    check("t4_done_c1", 32'(done), 0);
    @(negedge clk); #1;
    check("t4_done_c2", 32'(done), 1);
    check("t4_busy_c2", 32'(busy), 0);
    @(negedge clk); #1;
    check("t4_done_c3", 32'(done), 0);
    check("t4_no_cyc", 32'(bursts_seen - b0), 0);

    // Reset while beat 3 of 8 is pending
    ack_pct = 100; ready_pct = 100;
    start_xfer("t5", 32'h0000_4000, 8);
    waited = 0;
    while ((beats_seen - k0) < 2 && waited < 200) begin
      @(negedge clk); #1;
      waited++;
    end
    check("t5_two_beats", 32'(beats_seen - k0), 2);
    ack_pct = 0;
    @(negedge clk); #1;
    check("t5_beat3_adr", wb_adr, 32'h0000_4008);
    check("t5_beat3_stb", 32'(wb_stb), 1);
    mon_en = 1'b0;
    rst = 1'b0;
    @(negedge clk); #1;
    check("t5_after_reset", {wb_cyc, wb_stb, busy, out_valid, done}, '0);
    check("t5_after_reset_adr", wb_adr, 0);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      check("t5_no_done", {done, busy}, '0);
    end
    clear_model();
    ack_pct = 100;
    mon_en = 1'b1;
    run_xfer("t5_restart", 32'h0000_5004, 9);

    // Address wrap, and a start pulse during the transfer
    start_xfer("t6", 32'hFFFF_FFF8, 4);
    repeat (2) @(negedge clk);
    #1;
    check("t6_busy_before_stray", 32'(busy), 1);
    base_adr = 32'h0000_0000; nb_words = 16'd3; start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    finish_xfer("t6", 4);

    // Random blocks under random slave stalls and consumer back-pressure
    for (int t = 0; t < 6; t++) begin
      ack_pct   = $urandom_range(30, 100);
      ready_pct = $urandom_range(20, 100);
      run_xfer("rand", $urandom(), $urandom_range(1, 40));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
